// File: rtl/event_scheduler_if.sv
// Control/status bundle for event_scheduler: run control, channel configuration and run status.
interface event_scheduler_if #(
    parameter int NUM_CH = 4,
    parameter int TW     = 16,
    parameter int CW     = 2
);
    logic              start;
    logic              stop;
    logic              chain_mode;
    logic [NUM_CH-1:0] ch_en;
    logic [TW-1:0]     finish_time;
    logic              cfg_we;
    logic [CW-1:0]     cfg_ch;
    logic [TW-1:0]     cfg_val;
    logic [TW-1:0]     now;
    logic [NUM_CH-1:0] fire;
    logic [NUM_CH-1:0] fired;
    logic              running;
    logic              done;

    modport master (
        output start, stop, chain_mode, ch_en, finish_time, cfg_we, cfg_ch, cfg_val,
        input  now, fire, fired, running, done
    );

    modport slave (
        input  start, stop, chain_mode, ch_en, finish_time, cfg_we, cfg_ch, cfg_val,
        output now, fire, fired, running, done
    );
endinterface

// File: rtl/event_scheduler.sv
// Programmable event scheduler: run timer plus NUM_CH compare channels, absolute or chained.
//
//   state  | meaning
//   S_IDLE | waiting for start, compare registers writable
//   S_RUN  | now counting up from 0, channels fire on match
//   S_DONE | finish_time reached, now frozen, registers writable
module event_scheduler #(
    parameter int NUM_CH = 4,
    parameter int TW     = 16,
    parameter int CW     = 2
) (
    input logic clk,
    input logic rst,
    event_scheduler_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     cmp_q [NUM_CH];
    logic              mode_q;
    logic [NUM_CH-1:0] en_q;
    logic [TW-1:0]     fin_q;
    logic [TW-1:0]     now_q;
    logic [NUM_CH-1:0] fired_q;
    logic [NUM_CH-1:0] fire_c;

    // chain tracking: pending channel, time of previous fire, whether pending is the head
    logic [CW-1:0]     ptr_q;
    logic [TW-1:0]     base_q;
    logic              head_q;
    logic              live_q;

    logic              start_acc;
    logic              cfg_ok;
    logic [TW-1:0]     cmp_cur;
    logic [TW-1:0]     delay;
    logic [TW:0]       chain_tgt;
    logic              chain_hit;
    logic [NUM_CH-1:0] above;
    logic [CW:0]       nxt;
    logic [CW:0]       first;

    function automatic logic [CW:0] lowest_set(input logic [NUM_CH-1:0] m);
        logic [CW:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i]) r = {1'b1, CW'(i)};
        end
        return r;
    endfunction

    assign start_acc = bus.start && !bus.stop && (state_q != S_RUN);
    assign cfg_ok    = bus.cfg_we && (state_q != S_RUN);

    // target carries one extra bit so an overflowed target can never equal now
    assign cmp_cur   = cmp_q[ptr_q];
    assign delay     = (cmp_cur == '0) ? TW'(1) : cmp_cur;
    assign chain_tgt = head_q ? {1'b0, cmp_cur} : ({1'b0, base_q} + {1'b0, delay});
    assign chain_hit = live_q && (chain_tgt == {1'b0, now_q});
    assign above     = en_q & (({NUM_CH{1'b1}} << ptr_q) << 1);
    assign nxt       = lowest_set(above);
    assign first     = lowest_set(bus.ch_en);

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        fire_c  = '0;
        if (bus.stop) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (bus.start) state_d = S_RUN;
                S_RUN:   if (now_q == fin_q) state_d = S_DONE;
                S_DONE:  if (bus.start) state_d = S_RUN;
                default: state_d = S_IDLE;
            endcase
        end
        if (state_q == S_RUN) begin
            if (mode_q) begin
                if (chain_hit) fire_c[ptr_q] = 1'b1;
            end else begin
                for (int i = 0; i < NUM_CH; i++) begin
                    fire_c[i] = en_q[i] && (cmp_q[i] == now_q);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) cmp_q[i] <= '0;
            mode_q  <= 1'b0;
            en_q    <= '0;
            fin_q   <= '0;
            now_q   <= '0;
            fired_q <= '0;
            ptr_q   <= '0;
            base_q  <= '0;
            head_q  <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            if (cfg_ok && (int'(bus.cfg_ch) < NUM_CH)) cmp_q[bus.cfg_ch] <= bus.cfg_val;
            if (bus.stop) begin
                now_q   <= '0;
                fired_q <= '0;
                live_q  <= 1'b0;
            end else if (start_acc) begin
                mode_q  <= bus.chain_mode;
                en_q    <= bus.ch_en;
                fin_q   <= bus.finish_time;
                now_q   <= '0;
                fired_q <= '0;
                {live_q, ptr_q} <= first;
                head_q  <= 1'b1;
                base_q  <= '0;
            end else if (state_q == S_RUN) begin
                fired_q <= fired_q | fire_c;
                if (now_q != fin_q) now_q <= now_q + TW'(1);
                if (mode_q && chain_hit) begin
                    head_q <= 1'b0;
                    base_q <= now_q;
                    {live_q, ptr_q} <= nxt;
                end
            end
        end
    end

    assign bus.now     = now_q;
    assign bus.fire    = fire_c;
    assign bus.fired   = fired_q;
    assign bus.running = (state_q == S_RUN);
    assign bus.done    = (state_q == S_DONE);
endmodule

// File: tb/tb_event_scheduler.sv
// Bench for event_scheduler (TW=9 so overflow and full-range finish stay short): table, corner sequences, random vs model.
module tb_event_scheduler;
    localparam int NCH = 4;
    localparam int TWB = 9;
    localparam int CWB = 2;
    localparam logic [15:0] NEVER = 16'hFFFF;

    typedef struct {
        logic            mode;
        logic [3:0]      en;
        int              fin;
        logic [3:0][15:0] cmp;
        logic [3:0][15:0] t;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_fail = 0;
    vec_t tbl [10];

    event_scheduler_if #(.NUM_CH(NCH), .TW(TWB), .CW(CWB)) bus ();

    event_scheduler #(.NUM_CH(NCH), .TW(TWB), .CW(CWB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic cfg_write(input int ch, input int val);
        bus.cfg_we  = 1'b1;
        bus.cfg_ch  = CWB'(ch);
        bus.cfg_val = TWB'(val);
        step();
        bus.cfg_we  = 1'b0;
    endtask

    task automatic do_start(input logic m, input logic [3:0] e, input int f);
        bus.chain_mode  = m;
        bus.ch_en       = e;
        bus.finish_time = TWB'(f);
        bus.start       = 1'b1;
        step();
        bus.start       = 1'b0;
    endtask

    function automatic vec_t mk(input logic m, input logic [3:0] e, input int f,
                                input int c0, input int c1, input int c2, input int c3,
                                input int t0, input int t1, input int t2, input int t3);
        vec_t v;
        v.mode = m; v.en = e; v.fin = f;
        v.cmp[0] = 16'(c0); v.cmp[1] = 16'(c1); v.cmp[2] = 16'(c2); v.cmp[3] = 16'(c3);
        v.t[0] = 16'(t0); v.t[1] = 16'(t1); v.t[2] = 16'(t2); v.t[3] = 16'(t3);
        return v;
    endfunction

    // Reference: fire time per channel straight from the scheduling rules
    function automatic vec_t model(input vec_t v);
        vec_t r;
        int   prev;
        int   tt;
        bit   alive;
        r = v; prev = -1; alive = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            r.t[i] = NEVER;
            if (!v.en[i]) continue;
            if (!v.mode) begin
                if (int'(v.cmp[i]) <= v.fin) r.t[i] = v.cmp[i];
            end else if (alive) begin
                tt = (prev < 0) ? int'(v.cmp[i])
                                : prev + ((v.cmp[i] == 16'd0) ? 1 : int'(v.cmp[i]));
                if (tt > v.fin) alive = 1'b0;
                else begin
                    r.t[i] = 16'(tt);
                    prev   = tt;
                end
            end
        end
        return r;
    endfunction

    task automatic run_vec(input vec_t v, input int id);
        logic [3:0] exp_fire;
        logic [3:0] sticky;
        string      tag;
        tag = $sformatf("vec%0d", id);
        for (int i = 0; i < NCH; i++) cfg_write(i, int'(v.cmp[i]));
        do_start(v.mode, v.en, v.fin);
        sticky = '0;
        for (int c = 0; c <= v.fin; c++) begin
            for (int i = 0; i < NCH; i++) exp_fire[i] = (v.t[i] == 16'(c));
            chk({tag, " now"}, 32'(bus.now), 32'(c));
            chk({tag, " running"}, 32'(bus.running), 32'd1);
            chk({tag, " fire"}, 32'(bus.fire), 32'(exp_fire));
            chk({tag, " fired"}, 32'(bus.fired), 32'(sticky));
            sticky |= exp_fire;
            step();
        end
        chk({tag, " done"}, 32'(bus.done), 32'd1);
        chk({tag, " end running"}, 32'(bus.running), 32'd0);
        chk({tag, " end now"}, 32'(bus.now), 32'(v.fin));
        chk({tag, " end fire"}, 32'(bus.fire), 32'd0);
        chk({tag, " end fired"}, 32'(bus.fired), 32'(sticky));
    endtask

    initial begin
        logic [3:0] seen;
        vec_t       rv;
        int         fin_r;

        rst = 1'b1;
        bus.start = 1'b0; bus.stop = 1'b0; bus.chain_mode = 1'b0; bus.ch_en = '0;
        bus.finish_time = '0; bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_val = '0;
        step(); step();
        rst = 1'b0;
        chk("reset now", 32'(bus.now), 32'd0);
        chk("reset fire", 32'(bus.fire), 32'd0);
        chk("reset fired", 32'(bus.fired), 32'd0);
        chk("reset running", 32'(bus.running), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);

        tbl[0] = mk(0, 4'b1111, 201, 50, 100, 150, 200, 50, 100, 150, 200);
        tbl[1] = mk(0, 4'b1111, 200, 100, 300, 200, 301, 100, -1, 200, -1);
        tbl[2] = mk(1, 4'b1011, 500, 50, 50, 0, 50, 50, 100, -1, 150);
        tbl[3] = mk(1, 4'b1111, 500, 50, 50, 0, 50, 50, 100, 101, 151);
        tbl[4] = mk(1, 4'b1111, 511, 400, 200, 0, 0, 400, -1, -1, -1);
        tbl[5] = mk(1, 4'b1111, 511, 400, 111, 0, 0, 400, 511, -1, -1);
        tbl[6] = mk(0, 4'b1111, 10, 10, 10, 10, 10, 10, 10, 10, 10);
        tbl[7] = mk(0, 4'b0111, 0, 0, 5, 0, 3, 0, -1, 0, -1);
        tbl[8] = mk(1, 4'b1100, 20, 1, 2, 3, 4, -1, -1, 3, 7);
        tbl[9] = mk(0, 4'b0101, 9, 7, 7, 7, 7, 7, -1, 7, -1);
        for (int k = 0; k < 10; k++) run_vec(tbl[k], k);

        // stop mid-run: outputs clear, no later fires
        for (int i = 0; i < NCH; i++) cfg_write(i, 50 * (i + 1));
        do_start(1'b0, 4'b1111, 201);
        repeat (75) step();
        chk("stop pre now", 32'(bus.now), 32'd75);
        chk("stop pre fired", 32'(bus.fired), 32'b0001);
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        chk("stop running", 32'(bus.running), 32'd0);
        chk("stop done", 32'(bus.done), 32'd0);
        chk("stop now", 32'(bus.now), 32'd0);
        chk("stop fired", 32'(bus.fired), 32'd0);
        seen = '0;
        for (int c = 0; c < 200; c++) begin
            seen |= bus.fire;
            step();
        end
        chk("stop no fire", 32'(seen), 32'd0);

        // cfg write during RUN ignored; restart from DONE; start in RUN ignored
        cfg_write(0, 50);
        do_start(1'b0, 4'b0001, 60);
        repeat (3) step();
        cfg_write(0, 5);
        chk("run cfg now", 32'(bus.now), 32'd4);
        step();
        chk("run cfg ignored", 32'(bus.fire), 32'd0);
        repeat (45) step();
        chk("run cfg keep", 32'(bus.fire), 32'b0001);
        repeat (11) step();
        chk("done reached", 32'(bus.done), 32'd1);
        do_start(1'b0, 4'b0001, 60);
        chk("restart now", 32'(bus.now), 32'd0);
        chk("restart running", 32'(bus.running), 32'd1);
        chk("restart done", 32'(bus.done), 32'd0);
        repeat (20) step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("start in run ignored", 32'(bus.now), 32'd21);
        repeat (29) step();
        chk("restart fire", 32'(bus.fire), 32'b0001);
        repeat (11) step();

        // cfg write together with start is used by that run
        bus.cfg_we = 1'b1; bus.cfg_ch = 2'd1; bus.cfg_val = 9'd20;
        do_start(1'b1, 4'b0010, 30);
        bus.cfg_we = 1'b0;
        repeat (19) step();
        chk("cfg+start early", 32'(bus.fire), 32'd0);
        step();
        chk("cfg+start fire", 32'(bus.fire), 32'b0010);

        // rst mid-run behaves like stop and clears compare registers
        repeat (11) step();
        do_start(1'b0, 4'b0010, 100);
        repeat (30) step();
        chk("rst pre fired", 32'(bus.fired), 32'b0010);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst running", 32'(bus.running), 32'd0);
        chk("rst done", 32'(bus.done), 32'd0);
        chk("rst now", 32'(bus.now), 32'd0);
        chk("rst fired", 32'(bus.fired), 32'd0);
        do_start(1'b0, 4'b1111, 0);
        chk("rst cmp cleared", 32'(bus.fire), 32'b1111);
        step();
        chk("fin0 done", 32'(bus.done), 32'd1);

        // stop beats start in the same cycle
        bus.stop = 1'b1;
        do_start(1'b0, 4'b1111, 5);
        bus.stop = 1'b0;
        chk("stop wins running", 32'(bus.running), 32'd0);
        chk("stop wins done", 32'(bus.done), 32'd0);

        for (int k = 0; k < 40; k++) begin
            rv.mode = 1'($urandom_range(0, 1));
            rv.en   = 4'($urandom_range(0, 15));
            fin_r   = ($urandom_range(0, 5) == 0) ? 511 : int'($urandom_range(0, 250));
            rv.fin  = fin_r;
            for (int i = 0; i < NCH; i++) begin
                if (rv.mode)
                    rv.cmp[i] = 16'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 511)
                                                                 : $urandom_range(0, 80));
                else
                    rv.cmp[i] = 16'($urandom_range(0, fin_r + 20 > 511 ? 511 : fin_r + 20));
            end
            rv = model(rv);
            run_vec(rv, 100 + k);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/event_scheduler.md
Name: event_scheduler

Overview:
- Programmable hardware event scheduler: free-running time counter plus NUM_CH compare channels; each channel emits a one-cycle fire pulse at its scheduled time, and the run terminates at a programmable finish time.
- Two modes:
  - absolute: each channel fires at its own compare value.
  - chained: each channel's value is a delay relative to the previous enabled channel's fire.
- Sits in the verification/control fabric as the synthesizable replacement for delay-driven stimulus and finish control.

Parameters:
NUM_CH, 4, number of event channels (2..16)
TW, 16, width of time counter and compare values
CW, 2, channel index width, equals clog2(NUM_CH)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  pulse: begin (or restart) a run
stop  in  1  pulse: abort run, return to IDLE
chain_mode  in  1  0 = absolute, 1 = chained; sampled when start is accepted
ch_en  in  NUM_CH  channel enable mask; sampled when start is accepted
finish_time  in  TW  terminal time; sampled when start is accepted
cfg_we  in  1  write compare register
cfg_ch  in  CW  compare register index
cfg_val  in  TW  compare value / delay
now  out  TW  current run time
fire  out  NUM_CH  one-cycle pulse per channel event
fired  out  NUM_CH  sticky mask of channels fired this run
running  out  1  high in RUN
done  out  1  high in DONE

Behaviour:
- Reset values:
  - state IDLE.
  - now=0, fire=0, fired=0, running=0, done=0.
  - All compare registers cleared to 0; sampled mode/mask/finish cleared to 0.
- States: IDLE, RUN, DONE.
  - IDLE, start=1 -> RUN.
  - RUN, cycle with now==finish_time -> DONE.
  - DONE, start=1 -> RUN (restart).
  - Any state, stop=1 -> IDLE.
  - stop and start in the same cycle: stop wins.
- cfg_we is honoured only in IDLE or DONE, and is ignored in RUN.
  - A write in the same cycle as an accepted start is applied and used by that run.
- Start accepted in cycle k:
  - In cycle k+1: running=1, now=0, fired=0, all enabled channels armed.
  - now increments by 1 every RUN cycle.
- Absolute mode:
  - fire[i]=1 in the RUN cycle where now==cmp[i] and ch_en[i]=1.
  - Each channel fires at most once per run.
  - Several channels may fire in the same cycle.
- Chained mode:
  - Channels are processed in ascending index order; disabled channels are skipped.
  - The first enabled channel's target is cmp[first].
  - When channel i fires at time t, the next enabled channel's target is t+max(cmp[next],1). A zero delay therefore means the next cycle, and there is at most one fire per cycle.
  - Targets are computed with TW+1 bits. A carry-out means the target is unreachable and the channel never fires.
  - Subsequent channels are unreachable as well.
- fire is asserted in the same cycle that now shows the matching value.
  - fired[i] is set from the following cycle and holds until the next accepted start or stop.
- Finish:
  - Channels whose target equals finish_time fire in the finish cycle.
  - Targets greater than finish_time never fire.
  - The cycle after the finish cycle: running=0, done=1, now holds finish_time, fire=0.
- done stays high until start, stop or rst.
- finish_time=0: RUN lasts exactly one cycle (now=0); cmp=0 channels fire in it.
- now never wraps, because the run ends at finish_time ≤ 2^TW-1.
- stop or rst mid-run: the next cycle is IDLE with now=0, fire=0, running=0, done=0; fired is cleared.
- start while already in RUN: ignored.

Test Plan:
1. Absolute mode, cmp={50,100,150,200}, ch_en=4'b1111, finish=201:
   - fire[0..3] at now=50, 100, 150, 200 respectively, one cycle each.
   - done rises at the cycle after now=201; fired=4'b1111.
2. Absolute mode, cmp={100,300,200,301}, finish=200:
   - fire[0] at now=100 and fire[2] at now=200 (finish cycle).
   - ch1 and ch3 never fire; fired=4'b0101 at done.
3. Chained mode, cmp={50,50,0,50}, ch_en=4'b1011, finish=500:
   - fire[0]@50, fire[1]@100, fire[3]@150; ch2 is skipped.
   - Then, with ch_en=4'b1111: fire[0]@50, fire[1]@100, fire[2]@101, fire[3]@151.
4. Chained mode, TW=8, cmp={200,100,…}, finish=255:
   - fire[0]@200.
   - The ch1 target (300) overflows, so no further fires; done after now=255.
5. Simultaneous events, absolute mode, cmp={10,10,10,10}, finish=10:
   - All four fire bits are high in the same cycle at now=10.
   - Next cycle: done=1, running=0.
6. Control edge cases:
   - stop at now=75 in scenario 1: next cycle IDLE, now=0, fired=0; fire[1..3] never occur.
   - cfg_we with cfg_val=5 during RUN: ignored.
   - cfg_we concurrent with start: used by that run.
   - rst asserted mid-run: same state as stop.
   - start in DONE: restarts from now=0.
